// File: rtl/rcservo_pkg.sv
// Scaling constants, FSM states and result payload shared by the RC servo generator and decoder.
package rcservo_pkg;

  localparam int unsigned TICKS_PER_MS    = 256;
  localparam int unsigned POS_MIN_TICKS   = 256;
  localparam int unsigned POS_MAX_TICKS   = 511;
  localparam int unsigned CLK_DIV_DEFAULT = 98;

  localparam int unsigned MIN_TICKS     = 64;
  localparam int unsigned MAX_TICKS     = 1024;
  localparam int unsigned TIMEOUT_TICKS = 8192;

  localparam int unsigned POS_W     = 8;
  localparam int unsigned WIDTH_W   = 12;
  localparam int unsigned TIMEOUT_W = 14;

  typedef enum logic [1:0] {ARM, LOW, HIGH} rc_state_e;

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic             clamped;
  } rc_sample_t;

  // Map an accepted high width in ticks to a saturated 8-bit position.
  function automatic rc_sample_t map_width(input logic [WIDTH_W-1:0] w);
    rc_sample_t s;
    if (w < WIDTH_W'(POS_MIN_TICKS)) begin
      s.pos     = '0;
      s.clamped = 1'b1;
    end else if (w > WIDTH_W'(POS_MAX_TICKS)) begin
      s.pos     = '1;
      s.clamped = 1'b1;
    end else begin
      s.pos     = w[POS_W-1:0];
      s.clamped = 1'b0;
    end
    return s;
  endfunction

endpackage

// File: rtl/rcservo_decoder_if.sv
// PWM input and decoded position outputs of the RC servo decoder.
interface rcservo_decoder_if;
  import rcservo_pkg::*;

  logic             in;
  logic [POS_W-1:0] pos;
  logic             pos_valid;
  logic             clamped;
  logic             present;

  modport master (input in, output pos, output pos_valid, output clamped, output present);
  modport slave  (output in, input pos, input pos_valid, input clamped, input present);
endinterface

// File: rtl/rcservo_tick_gen.sv
// Free-running clk-to-tick prescaler with synchronous restart and a registered one-cycle tick.
module rcservo_tick_gen
  import rcservo_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= (count == LAST);
      if (restart || count == LAST) count <= '0;
      else                          count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rcservo_decoder.sv
// Measures RC servo PWM high time in ticks and recovers the commanded 8-bit position.
module rcservo_decoder
  import rcservo_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  rcservo_decoder_if.master  bus
);

  localparam logic [WIDTH_W-1:0]   W_MIN   = WIDTH_W'(MIN_TICKS);
  localparam logic [WIDTH_W-1:0]   W_MAX   = WIDTH_W'(MAX_TICKS);
  localparam logic [TIMEOUT_W-1:0] T_LIMIT = TIMEOUT_W'(TIMEOUT_TICKS);

  // Synchronizer and edge history are left unreset so a line held high
  // through reset still reads high and ARM will not measure a partial pulse.
  logic s1, s2, prev;
  logic rise_q, fall_q;

  always_ff @(posedge clk) begin
    s1   <= bus.in;
    s2   <= s1;
    prev <= s2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= s2 & ~prev;
      fall_q <= ~s2 & prev;
    end
  end

  // Restart from the edge one stage ahead; with the registered tick this
  // aligns the tick phase so the width comes out as floor(N/CLK_DIV).
  logic tick;
  logic restart_c;
  assign restart_c = s1 & ~s2;

  rcservo_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .restart (restart_c),
    .tick    (tick)
  );

  rc_state_e            state;
  logic [WIDTH_W-1:0]   width;
  logic [TIMEOUT_W-1:0] tcnt;
  logic [POS_W-1:0]     pos_q;
  logic                 pos_valid_q;
  logic                 clamped_q;
  logic                 present_q;

  logic       accept_c;
  rc_sample_t sample_c;

  assign accept_c = (state == HIGH) && fall_q && (width != W_MAX) && (width >= W_MIN);
  assign sample_c = map_width(width);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARM;
      width       <= '0;
      tcnt        <= '0;
      pos_q       <= '0;
      pos_valid_q <= 1'b0;
      clamped_q   <= 1'b0;
      present_q   <= 1'b0;
    end else begin
      pos_valid_q <= 1'b0;

      case (state)
        ARM:  if (!s2) state <= LOW;
        LOW:  if (rise_q) begin
                state <= HIGH;
                width <= '0;
              end
        HIGH: if (width == W_MAX)  state <= ARM;
              else if (fall_q)     state <= LOW;
              else if (tick)       width <= width + WIDTH_W'(1);
        default: state <= ARM;
      endcase

      // An accepted pulse outranks a coincident timeout expiry.
      if (accept_c) begin
        pos_q       <= sample_c.pos;
        clamped_q   <= sample_c.clamped;
        pos_valid_q <= 1'b1;
        present_q   <= 1'b1;
        tcnt        <= '0;
      end else if (tick && tcnt != T_LIMIT) begin
        tcnt <= tcnt + TIMEOUT_W'(1);
        if (tcnt == T_LIMIT - TIMEOUT_W'(1)) present_q <= 1'b0;
      end
    end
  end

  assign bus.pos       = pos_q;
  assign bus.pos_valid = pos_valid_q;
  assign bus.clamped   = clamped_q;
  assign bus.present   = present_q;

endmodule

// File: doc/rcservo_decoder.md
# rcservo_decoder

Receive-side counterpart to the CPLD's RC servo pulse generator. Measures the high time of an incoming RC servo PWM signal at 256 ticks/ms and recovers the 8-bit position, where 1.000 ms maps to 0 and 1.996 ms maps to 255. Sits between an external RC receiver or servo-tester pin and the SPI register file, so the host can read back commanded servo positions and confirm that the link is alive.

## Interface
- ClkDiv, 98, clk cycles per tick (25 MHz / 1000 / 256).
- MinTicks, 64, high widths below this (0.25 ms) are glitches and are dropped.
- MaxTicks, 1024, high widths reaching this (4 ms) mean the line is stuck high.
- TimeoutTicks, 8192, ticks with no accepted pulse before `present` drops (32 ms).

Ports:
- clk  in  1  system clock, 25 MHz
- rst  in  1  synchronous, active-high reset
- in  in  1  asynchronous RC PWM input
- pos  out  8  last accepted position
- pos_valid  out  1  one-cycle strobe when `pos` updates
- clamped  out  1  the last accepted pulse was outside 1–2 ms and its position was saturated
- present  out  1  an accepted pulse arrived within the last TimeoutTicks

## Operation
- `in` passes through a 2-FF synchronizer, then a third register (`prev`) for edge detection.
- `rise` = s2 & ~prev; `fall` = ~s2 & prev.
- FSM states:
  - ARM: waits for s2 == 0, then goes to LOW. This prevents measuring a partial pulse after reset.
  - LOW: on `rise`, go to HIGH, clear `width`, and restart the prescaler.
  - HIGH: width++ on each tick, 12-bit.
    - If width reaches MaxTicks, go to ARM with no output.
    - On `fall`, evaluate the pulse and go to LOW.
- Evaluation at `fall`, with w = width:
  - w < MinTicks: discard. No strobe; `present` and the timeout counter are unaffected.
  - MinTicks ≤ w < 256: pos=0, clamped=1.
  - 256 ≤ w ≤ 511: pos=w−256, i.e. w[7:0], clamped=0.
  - 512 ≤ w < MaxTicks: pos=255, clamped=1.
  - Any accepted case pulses pos_valid, sets present=1 and clears the timeout counter.
- Prescaler: ClkCount runs 0..ClkDiv−1 and a tick is produced when ClkCount==ClkDiv−1. It is free-running except for the restart on `rise`. The measured width is floor(N/ClkDiv), where N is the number of cycles s2 is high.
- Timeout counter: 14-bit, counts ticks in all states and saturates at TimeoutTicks. On reaching TimeoutTicks, present=0. `pos` and `clamped` hold their values.

## Timing
- Reset values: pos=0, pos_valid=0, clamped=0, present=0, FSM=ARM, all counters 0.
- Reset mid-pulse abandons the measurement. The next state is ARM.
- Latency: if `in` is first sampled low at clk edge k, `pos`, `clamped` and `pos_valid` update at edge k+3. `pos_valid` is high for exactly one cycle.
- Simultaneous tick and `fall`: the tick is ignored, and the evaluated width is the pre-increment value.
- Simultaneous width==MaxTicks and `fall`: MaxTicks takes priority, so there is no output.
- Simultaneous timeout expiry and an accepted pulse: the accepted pulse wins, so present=1 and the counter is cleared.
- Minimum pulse spacing: back-to-back pulses need one low cycle after synchronization; `rise` in LOW is accepted in the cycle after `fall`.

## Structure
- Shared package `rcservo_pkg` holds:
  - TICKS_PER_MS=256.
  - POS_MIN_TICKS=256 and POS_MAX_TICKS=511.
  - The default ClkDiv.
  - The FSM state enum {ARM, LOW, HIGH}.
- The package is shared with the generator so both ends agree on scaling.
- One sub-module, `rcservo_tick_gen`: the ClkDiv prescaler with a synchronous restart input and a one-cycle `tick` output. The generator can reuse it.

## Test plan
- 1.5 ms pulse (37632 clk high), then low: pos=128, clamped=0, a single pos_valid, present=1.
- 0.9 ms pulse (230 ticks) gives pos=0, clamped=1. 2.2 ms pulse (563 ticks) gives pos=255, clamped=1.
- 10 µs glitch (250 clk) between valid pulses: no pos_valid, and pos keeps its previous value.
- Line held high 5 ms: no pos_valid; the FSM returns to ARM; the next 1.25 ms pulse after a low gives pos=64.
- Valid pulse, then 33 ms of low: present falls after 8192 ticks and pos holds. The next valid pulse sets present=1.
- rst asserted while `in` is high for 0.5 ms of a 1.5 ms pulse: that pulse gives no pos_valid. The following full pulse gives pos=128.
